// File: rtl/wb_pkg.sv
// Shared types and load-type encodings for the writeback stage.
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lq_fifo.sv
// Small synchronous FIFO of writeback entries with full/empty flags.
// Head is read combinationally so a pushed entry can be popped the following cycle.
module wb_lq_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem_q [DEPTH];
    wb_entry_t      mem_d [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           do_push;
    logic           do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_entry;
        end
    end

    assign head = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU completions and extended load responses onto one RF write port.
// Define WB_FWD_EN to add same-cycle forwarding outputs (fwd1_*/fwd2_*) toward decode.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_valid,
    output logic             exu_ready,
    input  logic             exu_wen,
    input  logic [4:0]       exu_rd,
    input  logic [31:0]      exu_data,
    input  logic             lsu_issue_valid,
    input  logic [4:0]       lsu_issue_rd,
    input  logic             lsu_rsp_valid,
    output logic             lsu_rsp_ready,
    input  logic [4:0]       lsu_rsp_rd,
    input  logic [31:0]      lsu_rsp_rdata,
    input  logic [2:0]       lsu_rsp_funct3,
    input  logic [1:0]       lsu_rsp_addr_lo,
    input  logic [4:0]       hz_rs1,
    input  logic [4:0]       hz_rs2,
    output logic             hz_stall,
    output logic             rf_wen,
    output logic [4:0]       rf_addr,
    output logic [31:0]      rf_data,
`ifdef WB_FWD_EN
    output logic             fwd1_hit,
    output logic [31:0]      fwd1_data,
    output logic             fwd2_hit,
    output logic [31:0]      fwd2_data,
`endif
    output logic [CNT_W-1:0] retire_cnt
);

    wb_entry_t          lq_push_entry;
    wb_entry_t          lq_head;
    logic               lq_push;
    logic               lq_pop;
    logic               lq_full;
    logic               lq_empty;

    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;
    logic               exu_fire;

    logic               rf_wen_q, rf_wen_d;
    logic [4:0]         rf_addr_q, rf_addr_d;
    logic [31:0]        rf_data_q, rf_data_d;
    logic [31:0]        busy_q, busy_d;
    logic [31:0]        busy_set;
    logic [31:0]        busy_clr;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

    // Load data extension, applied before the response enters the queue.
    always_comb begin
        ld_byte = lsu_rsp_rdata[{lsu_rsp_addr_lo, 3'b000} +: 8];
        ld_half = lsu_rsp_addr_lo[1] ? lsu_rsp_rdata[31:16] : lsu_rsp_rdata[15:0];
        case (lsu_rsp_funct3)
            F3_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_ext = {24'd0, ld_byte};
            F3_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_ext = {16'd0, ld_half};
            default: ld_ext = lsu_rsp_rdata;
        endcase
    end

    always_comb begin
        lsu_rsp_ready      = !lq_full;
        lq_push            = lsu_rsp_valid && !lq_full;
        lq_push_entry.rd   = lsu_rsp_rd;
        lq_push_entry.data = ld_ext;
        lq_pop             = !lq_empty;
    end

    wb_lq_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk        (clk),
        .rst_n      (rst),
        .push       (lq_push),
        .push_entry (lq_push_entry),
        .pop        (lq_pop),
        .head       (lq_head),
        .full       (lq_full),
        .empty      (lq_empty)
    );

    // Loads are older than anything in execute, so the queue head always wins.
    // An ALU write to a register with a load still outstanding must wait (WAW).
    always_comb begin
        exu_ready = lq_empty && !(exu_wen && busy_q[exu_rd] && (exu_rd != 5'd0));
        exu_fire  = exu_valid && exu_ready;
        rf_wen_d  = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (lq_pop) begin
            rf_wen_d  = (lq_head.rd != 5'd0);
            rf_addr_d = lq_head.rd;
            rf_data_d = lq_head.data;
        end else if (exu_fire) begin
            rf_wen_d  = exu_wen && (exu_rd != 5'd0);
            rf_addr_d = exu_rd;
            rf_data_d = exu_data;
        end
    end

    // x0 never becomes busy.
    assign busy_set[0] = 1'b0;
    assign busy_clr[0] = 1'b0;

    genvar gi;
    for (gi = 1; gi < 32; gi++) begin : g_busy
        assign busy_set[gi] = lsu_issue_valid && (lsu_issue_rd == 5'(gi));
        assign busy_clr[gi] = lq_pop && (lq_head.rd == 5'(gi));
    end

    // A newer issue to the same rd keeps the bit set over a concurrent pop.
    always_comb begin
        busy_d       = (busy_q & ~busy_clr) | busy_set;
        hz_stall     = ((hz_rs1 != 5'd0) && busy_q[hz_rs1]) ||
                       ((hz_rs2 != 5'd0) && busy_q[hz_rs2]);
        retire_cnt_d = retire_cnt_q + CNT_W'(rf_wen_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen_q     <= 1'b0;
            rf_addr_q    <= 5'd0;
            rf_data_q    <= 32'd0;
            busy_q       <= 32'd0;
            retire_cnt_q <= '0;
        end else begin
            rf_wen_q     <= rf_wen_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            busy_q       <= busy_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign rf_wen     = rf_wen_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data    = rf_data_q;
    assign retire_cnt = retire_cnt_q;

`ifdef WB_FWD_EN
    assign fwd1_hit  = rf_wen_q && (rf_addr_q == hz_rs1) && (hz_rs1 != 5'd0);
    assign fwd1_data = rf_data_q;
    assign fwd2_hit  = rf_wen_q && (rf_addr_q == hz_rs2) && (hz_rs2 != 5'd0);
    assign fwd2_data = rf_data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized lockstep bench for wb_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int LQ_DEPTH = 2;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             exu_valid, exu_ready, exu_wen;
    logic [4:0]       exu_rd;
    logic [31:0]      exu_data;
    logic             lsu_issue_valid;
    logic [4:0]       lsu_issue_rd;
    logic             lsu_rsp_valid, lsu_rsp_ready;
    logic [4:0]       lsu_rsp_rd;
    logic [31:0]      lsu_rsp_rdata;
    logic [2:0]       lsu_rsp_funct3;
    logic [1:0]       lsu_rsp_addr_lo;
    logic [4:0]       hz_rs1, hz_rs2;
    logic             hz_stall;
    logic             rf_wen;
    logic [4:0]       rf_addr;
    logic [31:0]      rf_data;
    logic [CNT_W-1:0] retire_cnt;
`ifdef WB_FWD_EN
    logic             fwd1_hit, fwd2_hit;
    logic [31:0]      fwd1_data, fwd2_data;
`endif

    wb_arbiter #(.LQ_DEPTH(LQ_DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .exu_valid       (exu_valid),
        .exu_ready       (exu_ready),
        .exu_wen         (exu_wen),
        .exu_rd          (exu_rd),
        .exu_data        (exu_data),
        .lsu_issue_valid (lsu_issue_valid),
        .lsu_issue_rd    (lsu_issue_rd),
        .lsu_rsp_valid   (lsu_rsp_valid),
        .lsu_rsp_ready   (lsu_rsp_ready),
        .lsu_rsp_rd      (lsu_rsp_rd),
        .lsu_rsp_rdata   (lsu_rsp_rdata),
        .lsu_rsp_funct3  (lsu_rsp_funct3),
        .lsu_rsp_addr_lo (lsu_rsp_addr_lo),
        .hz_rs1          (hz_rs1),
        .hz_rs2          (hz_rs2),
        .hz_stall        (hz_stall),
        .rf_wen          (rf_wen),
        .rf_addr         (rf_addr),
        .rf_data         (rf_data),
`ifdef WB_FWD_EN
        .fwd1_hit        (fwd1_hit),
        .fwd1_data       (fwd1_data),
        .fwd2_hit        (fwd2_hit),
        .fwd2_data       (fwd2_data),
`endif
        .retire_cnt      (retire_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes and a per-register busy table.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;

    ment_t            mq[$];
    bit               mbusy[32];
    bit               m_wen;
    logic [4:0]       m_addr;
    logic [31:0]      m_data;
    logic [CNT_W-1:0] m_cnt;
    bit               exu_acc, rsp_acc;
    logic [4:0]       pend[$];

    function automatic logic [31:0] ref_extend(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] lo);
        int unsigned b, h;
        b = (w >> (8 * lo)) % 256;
        h = (w >> (16 * (lo / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_cnt  = '0;
    endtask

    task automatic idle_inputs();
        exu_valid       = 1'b0;
        exu_wen         = 1'b0;
        exu_rd          = '0;
        exu_data        = '0;
        lsu_issue_valid = 1'b0;
        lsu_issue_rd    = '0;
        lsu_rsp_valid   = 1'b0;
        lsu_rsp_rd      = '0;
        lsu_rsp_rdata   = '0;
        lsu_rsp_funct3  = '0;
        lsu_rsp_addr_lo = '0;
        hz_rs1          = '0;
        hz_rs2          = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        bit    m_rdy_rsp, m_rdy_exu, m_stall;
        ment_t e;
        #1;
        m_rdy_rsp = (mq.size() < LQ_DEPTH);
        m_rdy_exu = (mq.size() == 0) && !(exu_wen && exu_rd != 0 && mbusy[exu_rd]);
        m_stall   = (hz_rs1 != 0 && mbusy[hz_rs1]) || (hz_rs2 != 0 && mbusy[hz_rs2]);
        check("lsu_rsp_ready", lsu_rsp_ready, m_rdy_rsp);
        check("exu_ready", exu_ready, m_rdy_exu);
        check("hz_stall", hz_stall, m_stall);
`ifdef WB_FWD_EN
        check("fwd1_hit", fwd1_hit, m_wen && m_addr == hz_rs1 && hz_rs1 != 0);
        check("fwd2_hit", fwd2_hit, m_wen && m_addr == hz_rs2 && hz_rs2 != 0);
        if (m_wen) check("fwd1_data", fwd1_data, m_data);
`endif
        @(posedge clk);
        exu_acc = 1'b0;
        rsp_acc = lsu_rsp_valid && m_rdy_rsp;
        m_cnt   = m_cnt + CNT_W'(m_wen);
        if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_wen  = (e.rd != 0);
            m_addr = e.rd;
            m_data = e.data;
            mbusy[e.rd] = 1'b0;
        end else if (exu_valid && m_rdy_exu) begin
            exu_acc = 1'b1;
            m_wen   = exu_wen && (exu_rd != 0);
            m_addr  = exu_rd;
            m_data  = exu_data;
        end else begin
            m_wen = 1'b0;
        end
        if (rsp_acc)
            mq.push_back('{rd: lsu_rsp_rd,
                           data: ref_extend(lsu_rsp_rdata, lsu_rsp_funct3, lsu_rsp_addr_lo)});
        if (lsu_issue_valid && lsu_issue_rd != 0) mbusy[lsu_issue_rd] = 1'b1;
        @(negedge clk);
        check("rf_wen", rf_wen, m_wen);
        if (m_wen) begin
            check("rf_addr", rf_addr, m_addr);
            check("rf_data", rf_data, m_data);
            $display("write x%0d <= %08h (retired %0d)", m_addr, m_data, m_cnt);
        end
        check("retire_cnt", retire_cnt, m_cnt);
    endtask

    logic [2:0]  ext_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
    logic [1:0]  ext_lo  [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [31:0] ext_exp [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF,
                                 32'h00007F01, 32'h80FF7F01};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst       = 1'b0;
        exu_valid = 1'b1;
        exu_wen   = 1'b1;
        exu_rd    = 5'd5;
        exu_data  = 32'h12345678;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rf_wen", rf_wen, 1'b0);
        check("rst_rf_addr", rf_addr, 5'd0);
        check("rst_rf_data", rf_data, 32'd0);
        check("rst_retire_cnt", retire_cnt, 0);
        rst = 1'b1;
        #1;
        check("exu_ready_after_rst", exu_ready, 1'b1);

        // ALU write, then x0 write.
        step();
        check("alu_rf_wen", rf_wen, 1'b1);
        check("alu_rf_addr", rf_addr, 5'd5);
        check("alu_rf_data", rf_data, 32'h12345678);
        exu_rd   = 5'd0;
        exu_data = 32'hDEADBEEF;
        step();
        check("x0_rf_wen", rf_wen, 1'b0);
        check("alu_retire_cnt", retire_cnt, 1);
        exu_valid = 1'b0;
        step();

        // Load extension, with the 2-cycle response-to-write latency.
        for (int k = 0; k < 5; k++) begin
            lsu_rsp_valid   = 1'b1;
            lsu_rsp_rd      = 5'd9;
            lsu_rsp_rdata   = 32'h80FF7F01;
            lsu_rsp_funct3  = ext_f3[k];
            lsu_rsp_addr_lo = ext_lo[k];
            step();
            check("ld_latency_wen", rf_wen, 1'b0);
            lsu_rsp_valid = 1'b0;
            step();
            check("ld_ext_data", rf_data, ext_exp[k]);
        end

        // Hazard: stall until the load is popped; re-issue in the pop cycle keeps it busy.
        lsu_issue_valid = 1'b1;
        lsu_issue_rd    = 5'd7;
        step();
        lsu_issue_valid = 1'b0;
        hz_rs1          = 5'd7;
        #1 check("hz_pending", hz_stall, 1'b1);
        step();
        lsu_rsp_valid  = 1'b1;
        lsu_rsp_rd     = 5'd7;
        lsu_rsp_rdata  = 32'hCAFE0007;
        lsu_rsp_funct3 = F3_LW;
        step();
        check("hz_queued", hz_stall, 1'b1);
        lsu_rsp_valid   = 1'b0;
        lsu_issue_valid = 1'b1;
        step();
        lsu_issue_valid = 1'b0;
        #1 check("hz_set_wins", hz_stall, 1'b1);
        lsu_rsp_valid = 1'b1;
        step();
        lsu_rsp_valid = 1'b0;
        step();
        #1 check("hz_cleared", hz_stall, 1'b0);
        hz_rs1 = 5'd0;

        // WAW: ALU write to a register with a pending load waits behind the load.
        lsu_issue_valid = 1'b1;
        lsu_issue_rd    = 5'd3;
        step();
        lsu_issue_valid = 1'b0;
        exu_valid       = 1'b1;
        exu_wen         = 1'b1;
        exu_rd          = 5'd3;
        exu_data        = 32'h0000AAAA;
        #1 check("waw_exu_ready", exu_ready, 1'b0);
        lsu_rsp_valid  = 1'b1;
        lsu_rsp_rd     = 5'd3;
        lsu_rsp_rdata  = 32'h11111111;
        lsu_rsp_funct3 = F3_LW;
        step();
        lsu_rsp_valid = 1'b0;
        step();
        check("waw_load_first", rf_data, 32'h11111111);
        step();
        check("waw_exu_second", rf_data, 32'h0000AAAA);
        exu_valid = 1'b0;
        step();

        // Back-to-back responses while execute keeps offering work.
        exu_valid      = 1'b1;
        exu_wen        = 1'b1;
        exu_rd         = 5'd10;
        exu_data       = 32'hE0;
        lsu_rsp_valid  = 1'b1;
        lsu_rsp_funct3 = F3_LW;
        for (int k = 0; k < 3; k++) begin
            lsu_rsp_rd    = 5'(11 + k);
            lsu_rsp_rdata = 32'hD0 + 32'(k);
            step();
            if (k >= 1) check("burst_order", rf_data, 32'hD0 + 32'(k - 1));
            if (exu_acc) begin
                exu_rd   = exu_rd + 5'd1;
                exu_data = exu_data + 32'd1;
            end
        end
        lsu_rsp_valid = 1'b0;
        repeat (4) begin
            step();
            if (exu_acc) begin
                exu_rd   = exu_rd + 5'd1;
                exu_data = exu_data + 32'd1;
            end
        end
        idle_inputs();
        step();

        // Randomized traffic; responses follow issued loads in order.
        exu_acc = 1'b0;
        rsp_acc = 1'b0;
        pend.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0;
                #1;
                check("midrst_rf_wen", rf_wen, 1'b0);
                check("midrst_retire", retire_cnt, 0);
                model_reset();
                pend.delete();
                idle_inputs();
                exu_acc = 1'b0;
                rsp_acc = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                continue;
            end
            if (!(exu_valid && !exu_acc)) begin
                exu_valid = ($urandom_range(0, 1) == 1);
                exu_wen   = ($urandom_range(0, 3) != 0);
                exu_rd    = 5'($urandom_range(0, 7));
                exu_data  = $urandom;
            end
            if (!(lsu_rsp_valid && !rsp_acc)) begin
                if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                    lsu_rsp_valid   = 1'b1;
                    lsu_rsp_rd      = pend[0];
                    lsu_rsp_rdata   = $urandom;
                    lsu_rsp_funct3  = 3'($urandom_range(0, 7));
                    lsu_rsp_addr_lo = 2'($urandom_range(0, 3));
                end else begin
                    lsu_rsp_valid = 1'b0;
                end
            end
            lsu_issue_valid = ($urandom_range(0, 3) == 0);
            lsu_issue_rd    = 5'($urandom_range(0, 7));
            hz_rs1          = 5'($urandom_range(0, 7));
            hz_rs2          = 5'($urandom_range(0, 7));
            step();
            if (rsp_acc) void'(pend.pop_front());
            if (lsu_issue_valid) pend.push_back(lsu_issue_rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
